// File: rtl/alu_exec_unit_pkg.sv
// rtl/alu_exec_unit_pkg.sv - shared ALU operation codes, control codes and PC step
package alu_exec_unit_pkg;

    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU = 6'h2B;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU with zero, signed-overflow and carry flags
module alu_core
    import alu_exec_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       alu_ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             ovf,
    output logic             cout
);

    logic [WIDTH:0] sum_add;
    logic [WIDTH:0] sum_sub;
    logic           signed_lt;

    assign sum_add = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign sum_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    // Differing signs decide directly, so an overflowing a-b never corrupts SLT.
    assign signed_lt = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : sum_sub[WIDTH-1];

    always_comb begin
        res  = '0;
        ovf  = 1'b0;
        cout = 1'b0;
        case (alu_ctl)
            ALU_ADD: begin
                res  = sum_add[WIDTH-1:0];
                cout = sum_add[WIDTH];
                ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_add[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                res  = sum_sub[WIDTH-1:0];
                cout = sum_sub[WIDTH];
                ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (sum_sub[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND:  res = a & b;
            ALU_OR:   res = a | b;
            ALU_XOR:  res = a ^ b;
            ALU_NOR:  res = ~(a | b);
            ALU_SLT:  res = {{(WIDTH-1){1'b0}}, signed_lt};
            ALU_SLTU: res = {{(WIDTH-1){1'b0}}, ~sum_sub[WIDTH]};
            default: begin
                res  = '0;
                ovf  = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

    assign zero = ~|res;

endmodule

// File: rtl/alu_ctl_decode.sv
// rtl/alu_ctl_decode.sv - maps funct-style alu_op to the 4-bit ALU control code
module alu_ctl_decode
    import alu_exec_unit_pkg::*;
(
    input  logic [5:0] alu_op,
    output logic [3:0] alu_ctl
);

    // Unlisted ops fall back to ADD so lw/sw address generation needs no special code.
    always_comb begin
        alu_ctl = ALU_ADD;
        case (alu_op)
            FUNCT_ADD, FUNCT_ADDU: alu_ctl = ALU_ADD;
            FUNCT_SUB, FUNCT_SUBU: alu_ctl = ALU_SUB;
            FUNCT_AND:             alu_ctl = ALU_AND;
            FUNCT_OR:              alu_ctl = ALU_OR;
            FUNCT_XOR:             alu_ctl = ALU_XOR;
            FUNCT_NOR:             alu_ctl = ALU_NOR;
            FUNCT_SLT:             alu_ctl = ALU_SLT;
            FUNCT_SLTU:            alu_ctl = ALU_SLTU;
            default:               alu_ctl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/word_adder.sv
// rtl/word_adder.sv - modulo 2^WIDTH adder with no carry output
module word_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] sum
);

    assign sum = x + y;

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute stage: ALU decode/evaluate, PC adders, debug result register
module alu_exec_unit #(
    parameter int          WIDTH   = 32,
    parameter int unsigned PC_STEP = alu_exec_unit_pkg::PC_STEP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] br_offset,
    output logic [3:0]       alu_ctl,
    output logic [WIDTH-1:0] alu_res,
    output logic             zero,
    output logic             ovf,
    output logic             cout,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] br_target,
    output logic [WIDTH-1:0] res_q,
    output logic [2:0]       flags_q
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

    alu_ctl_decode u_decode (
        .alu_op  (alu_op),
        .alu_ctl (alu_ctl)
    );

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .alu_ctl (alu_ctl),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .res     (alu_res),
        .zero    (zero),
        .ovf     (ovf),
        .cout    (cout)
    );

    word_adder #(.WIDTH(WIDTH)) u_pc_add (
        .x   (pc),
        .y   (STEP),
        .sum (pc_plus4)
    );

    word_adder #(.WIDTH(WIDTH)) u_br_add (
        .x   (pc_plus4),
        .y   (br_offset),
        .sum (br_target)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_q   <= '0;
            flags_q <= 3'b000;
        end else begin
            res_q   <= alu_res;
            flags_q <= {zero, ovf, cout};
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed self-checking bench for alu_exec_unit
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  alu_op;
    logic [31:0] a, b, pc, br_offset;
    logic        cin;
    logic [3:0]  alu_ctl;
    logic [31:0] alu_res, pc_plus4, br_target, res_q;
    logic        zero, ovf, cout;
    logic [2:0]  flags_q;

    int checks   = 0;
    int failures = 0;

    alu_exec_unit #(.WIDTH(32), .PC_STEP(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_op    (alu_op),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .pc        (pc),
        .br_offset (br_offset),
        .alu_ctl   (alu_ctl),
        .alu_res   (alu_res),
        .zero      (zero),
        .ovf       (ovf),
        .cout      (cout),
        .pc_plus4  (pc_plus4),
        .br_target (br_target),
        .res_q     (res_q),
        .flags_q   (flags_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [5:0] op, input logic [31:0] va, input logic [31:0] vb,
                         input logic vcin);
        @(negedge clk);
        alu_op = op;
        a      = va;
        b      = vb;
        cin    = vcin;
        #1;
    endtask

    task automatic check_alu(input string tag, input logic [3:0] e_ctl, input logic [31:0] e_res,
                             input logic e_zero, input logic e_ovf, input logic e_cout);
        check({tag, ".ctl"},  {28'd0, alu_ctl}, {28'd0, e_ctl});
        check({tag, ".res"},  alu_res, e_res);
        check({tag, ".flags"}, {29'd0, zero, ovf, cout}, {29'd0, e_zero, e_ovf, e_cout});
    endtask

    initial begin
        reset     = 1'b1;
        alu_op    = 6'h20;
        a         = 32'h0;
        b         = 32'h0;
        cin       = 1'b0;
        pc        = 32'h0;
        br_offset = 32'h0;
        #2;
        check("reset.res_q", res_q, 32'h0);
        check("reset.flags_q", {29'd0, flags_q}, 32'h0);
        check("reset.comb_zero", {31'd0, zero}, 32'h1);
        @(negedge clk);
        reset = 1'b0;

        apply(6'h20, 32'h7FFFFFFF, 32'h1, 1'b0);
        check_alu("add_ovf", 4'b0010, 32'h80000000, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("add_ovf.res_q", res_q, 32'h80000000);
        check("add_ovf.flags_q", {29'd0, flags_q}, 32'h2);

        apply(6'h20, 32'd5, 32'd6, 1'b1);
        check_alu("add_cin", 4'b0010, 32'd12, 1'b0, 1'b0, 1'b0);
        apply(6'h20, 32'hFFFFFFFF, 32'h1, 1'b0);
        check_alu("add_carry", 4'b0010, 32'h0, 1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("add_carry.flags_q", {29'd0, flags_q}, 32'h5);

        apply(6'h22, 32'h12345678, 32'h12345678, 1'b0);
        check_alu("sub_eq", 4'b0110, 32'h0, 1'b1, 1'b0, 1'b1);
        apply(6'h23, 32'h80000000, 32'h1, 1'b0);
        check_alu("sub_ovf", 4'b0110, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1);
        apply(6'h22, 32'd5, 32'd6, 1'b1);
        check_alu("sub_borrow", 4'b0110, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);

        apply(6'h24, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1);
        check_alu("and", 4'b0000, 32'hF000F000, 1'b0, 1'b0, 1'b0);
        apply(6'h25, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1);
        check_alu("or", 4'b0001, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0);
        apply(6'h26, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1);
        check_alu("xor", 4'b0011, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0);
        apply(6'h27, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1);
        check_alu("nor", 4'b1100, 32'h000F000F, 1'b0, 1'b0, 1'b0);

        apply(6'h2A, 32'hFFFFFFFF, 32'h1, 1'b0);
        check_alu("slt_neg", 4'b0111, 32'h1, 1'b0, 1'b0, 1'b0);
        apply(6'h2B, 32'hFFFFFFFF, 32'h1, 1'b0);
        check_alu("sltu_big", 4'b1000, 32'h0, 1'b1, 1'b0, 1'b0);
        apply(6'h2A, 32'h80000000, 32'h7FFFFFFF, 1'b0);
        check_alu("slt_ovf", 4'b0111, 32'h1, 1'b0, 1'b0, 1'b0);
        apply(6'h2B, 32'h80000000, 32'h7FFFFFFF, 1'b0);
        check_alu("sltu_msb", 4'b1000, 32'h0, 1'b1, 1'b0, 1'b0);
        apply(6'h2B, 32'h1, 32'hFFFFFFFF, 1'b0);
        check_alu("sltu_lt", 4'b1000, 32'h1, 1'b0, 1'b0, 1'b0);

        apply(6'h08, 32'h100, 32'h20, 1'b0);
        check_alu("unknown", 4'b0010, 32'h120, 1'b0, 1'b0, 1'b0);
        pc        = 32'h00400010;
        br_offset = 32'hFFFFFFF8;
        #1;
        check("pc_plus4", pc_plus4, 32'h00400014);
        check("br_back", br_target, 32'h0040000C);
        pc        = 32'hFFFFFFFC;
        br_offset = 32'h00000010;
        #1;
        check("pc_wrap", pc_plus4, 32'h0);
        check("br_wrap", br_target, 32'h10);

        apply(6'h21, 32'hDEADBEEF, 32'h0, 1'b0);
        @(posedge clk); #1;
        check("load.res_q", res_q, 32'hDEADBEEF);
        check("load.flags_q", {29'd0, flags_q}, 32'h0);
        #1;
        reset = 1'b1;
        #1;
        check("async.res_q", res_q, 32'h0);
        check("async.alu_res", alu_res, 32'hDEADBEEF);
        apply(6'h20, 32'h7FFFFFFF, 32'h1, 1'b0);
        @(posedge clk); #1;
        check("hold.res_q", res_q, 32'h0);
        check("hold.flags_q", {29'd0, flags_q}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("release.res_q", res_q, 32'h80000000);
        check("release.flags_q", {29'd0, flags_q}, 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute-stage arithmetic block of the single-cycle MIPS CPU. It decodes the 6-bit ALU operation from the main control into a 4-bit ALU control code and evaluates the 32-bit ALU with zero/overflow/carry flags. It also forms the sequential PC (pc+4) and the branch target with two 32-bit adders. ALU results and flags are available combinationally for the same-cycle datapath, and are also captured in a result register for debug and flag use.

Parameters:
WIDTH, 32, datapath width of the ALU and both adders.
PC_STEP, 4, constant added to pc to form pc_plus4.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high; clears the result register.
alu_op  input  6  ALU operation from control; funct-style encoding.
a  input  WIDTH  ALU operand A (rs read data).
b  input  WIDTH  ALU operand B (rt data or sign-extended imm, already muxed).
cin  input  1  carry-in; used only by ADD.
pc  input  WIDTH  current instruction address.
br_offset  input  WIDTH  sign-extended immediate, already shifted left by 2.
alu_ctl  output  4  decoded ALU control code.
alu_res  output  WIDTH  combinational ALU result.
zero  output  1  high when alu_res == 0.
ovf  output  1  signed overflow (ADD/SUB only).
cout  output  1  carry-out of bit WIDTH-1 (ADD/SUB only).
pc_plus4  output  WIDTH  pc + PC_STEP.
br_target  output  WIDTH  pc_plus4 + br_offset.
res_q  output  WIDTH  alu_res registered.
flags_q  output  3  {zero, ovf, cout} registered.

Behaviour:
- alu_op to alu_ctl decode (combinational):
  - 0x20/0x21 -> ADD 0010
  - 0x22/0x23 -> SUB 0110
  - 0x24 -> AND 0000
  - 0x25 -> OR 0001
  - 0x26 -> XOR 0011
  - 0x27 -> NOR 1100
  - 0x2A -> SLT 0111
  - 0x2B -> SLTU 1000
  - any other value -> ADD 0010 (covers lw/sw address calculation).
- ALU operations:
  - ADD: {cout,res} = a + b + cin; ovf = (a[31]==b[31]) && (res[31]!=a[31]).
  - SUB: res = a + ~b + 1; cin is ignored; cout = carry of that sum (1 means no borrow); ovf = (a[31]!=b[31]) && (res[31]!=a[31]).
  - AND/OR/XOR/NOR: bitwise; ovf = 0, cout = 0.
  - SLT: res = 1 if signed a < signed b, else 0. Computed correctly even when a-b overflows. ovf = 0, cout = 0.
  - SLTU: res = 1 if unsigned a < unsigned b, else 0. ovf = 0, cout = 0.
  - Any undefined alu_ctl code (cannot occur through the decoder): res = 0, flags = 0.
- zero = ~|alu_res, for every operation.
- Adders: modulo 2^WIDTH with no carry output. pc_plus4 wraps from 0xFFFFFFFC to 0. br_target uses two's-complement wrap, so a negative br_offset yields a backward target.
- All outputs except res_q and flags_q are purely combinational, with zero-cycle latency and no internal state.
- res_q and flags_q update on the rising clk edge with the current alu_res and {zero,ovf,cout}, giving 1-cycle latency.
- While reset is high: res_q = 0 and flags_q = 3'b000, asynchronously, regardless of clk. On the first edge after reset deasserts, the register captures normally.
- Combinational outputs ignore reset and stay valid during reset.

Decomposition:
- Shared package holds:
  - alu_op codes (FUNCT_ADD..FUNCT_SLTU)
  - alu_ctl codes (ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_NOR)
  - PC_STEP.
- Sub-modules: alu_ctl_decode (decoder), alu_core (ALU plus flags), and word_adder instantiated twice for pc_plus4 and br_target. The result register lives in the top level.

Test Plan:
- ADD overflow: alu_op=0x20, a=0x7FFFFFFF, b=1, cin=0 -> alu_ctl=0010, alu_res=0x80000000, ovf=1, cout=0, zero=0. One edge later, res_q=0x80000000 and flags_q=3'b010.
- SUB equal and carry: alu_op=0x22, a=b=0x12345678 -> alu_res=0, zero=1, cout=1, ovf=0. Also a=0x80000000, b=1 -> alu_res=0x7FFFFFFF, ovf=1. ADD carry: a=0xFFFFFFFF, b=1, cin=0 -> alu_res=0, cout=1, zero=1.
- Logic ops, with a=0xF0F0F0F0, b=0xFF00FF00:
  - AND -> 0xF000F000
  - OR -> 0xFFF0FFF0
  - XOR -> 0x0FF00FF0
  - NOR -> 0x000F000F
  - ovf and cout stay 0 in all four cases.
- Set-less-than, with a=0xFFFFFFFF, b=1: SLT -> 1 and SLTU -> 0. With a=0x80000000, b=0x7FFFFFFF: SLT -> 1.
- Unknown op and adders: alu_op=0x08, a=0x100, b=0x20 -> alu_ctl=0010, alu_res=0x120. With pc=0x00400010 and br_offset=0xFFFFFFF8: pc_plus4=0x00400014 and br_target=0x0040000C. With pc=0xFFFFFFFC: pc_plus4=0.
- Async reset: load res_q=0xDEADBEEF, then assert reset mid-cycle (between edges) -> res_q=0 and flags_q=0 immediately, with alu_res unchanged. Deassert reset -> the next edge captures the current alu_res.
